regbank_wb_sequencer: RTL

REGBANK_WB_SEQUENCER -- requirements
Module: regbank_wb_sequencer

---
 rtl/regbank_wb_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regbank_wb_sequencer.sv
// Queues register-bank write-back requests from the fast domain and presents one per
// slow_clock slot, holding every bank input stable across the slow rising edge.
module regbank_wb_sequencer #(
  parameter int REGISTER_LENGTH = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int PC_REGISTER     = 15,
  parameter int SP_REGISTER     = 14
) (
  input  logic                       fast_clock,
  input  logic                       reset,
  input  logic                       slow_clock,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_control,
  input  logic [3:0]                 req_dest,
  input  logic [REGISTER_LENGTH-1:0] req_data,
  input  logic [REGISTER_LENGTH-1:0] req_sp,
  output logic                       wb_enable,
  output logic [2:0]                 wb_control,
  output logic [3:0]                 wb_dest,
  output logic [REGISTER_LENGTH-1:0] wb_alu_result,
  output logic [REGISTER_LENGTH-1:0] wb_data_from_memory,
  output logic [REGISTER_LENGTH-1:0] wb_new_SP,
  output logic [15:0]                pending,
  output logic [3:0]                 fifo_count
);

  localparam int         PW         = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_C    = 4'(FIFO_DEPTH);
  localparam logic [3:0] PC_C       = 4'(PC_REGISTER);
  localparam logic [3:0] SP_C       = 4'(SP_REGISTER);
  localparam logic [2:0] CTRL_ALU   = 3'd1;
  localparam logic [2:0] CTRL_MEM   = 3'd3;
  localparam logic [2:0] CTRL_ENTER = 3'd4;
  localparam logic [2:0] CTRL_COPY  = 3'd6;

  // Registers an entry will write in the bank; SP is touched by everything but ALU/copy.
  function automatic logic [15:0] pending_mask(input logic [2:0] control, input logic [3:0] dest);
    logic [15:0] mask;
    logic        general;
    mask    = 16'h0000;
    general = (dest != PC_C) && (dest != SP_C);
    case (control)
      CTRL_ALU:   mask[dest] = general;
      CTRL_MEM: begin
        mask[dest] = general;
        mask[SP_C] = 1'b1;
      end
      CTRL_ENTER: begin
        mask[SP_C]  = 1'b1;
        mask[4'd13] = 1'b1;
      end
      CTRL_COPY:  mask[dest] = 1'b1;
      default:    mask[SP_C] = 1'b1;
    endcase
    return mask;
  endfunction

  logic [2:0]                 sync_r;
  logic [PW-1:0]              wr_ptr_r;
  logic [PW-1:0]              rd_ptr_r;
  logic [3:0]                 count_r;
  logic [2:0]                 ctrl_mem_r [FIFO_DEPTH];
  logic [3:0]                 dest_mem_r [FIFO_DEPTH];
  logic [REGISTER_LENGTH-1:0] data_mem_r [FIFO_DEPTH];
  logic [REGISTER_LENGTH-1:0] sp_mem_r   [FIFO_DEPTH];
  logic                       wb_enable_r;
  logic [2:0]                 wb_control_r;
  logic [3:0]                 wb_dest_r;
  logic [REGISTER_LENGTH-1:0] wb_alu_result_r;
  logic [REGISTER_LENGTH-1:0] wb_dfm_r;
  logic [REGISTER_LENGTH-1:0] wb_sp_r;
  logic [PW-1:0]              offset_s   [FIFO_DEPTH];
  logic [15:0]                pending_s;
  logic                       boundary_s;
  logic                       push_s;
  logic                       pop_s;

  // A flush swallows both the offered request and a coincident slot boundary.
  assign boundary_s = sync_r[2] & ~sync_r[1] & ~flush;
  assign req_ready  = (count_r < DEPTH_C);
  assign push_s     = req_valid & req_ready & ~flush;
  assign pop_s      = boundary_s & (count_r != 4'd0);

  // Two-flop slow_clock synchroniser; sync_r[2] holds the previous synced sample.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], slow_clock};
    end
  end

  // FIFO storage, written only on an accepted request.
  always_ff @(posedge fast_clock) begin
    if (push_s) begin
      ctrl_mem_r[wr_ptr_r] <= req_control;
      dest_mem_r[wr_ptr_r] <= req_dest;
      data_mem_r[wr_ptr_r] <= req_data;
      sp_mem_r[wr_ptr_r]   <= req_sp;
    end
  end

  // FIFO pointers/occupancy and the presented entry, which only changes on a slot boundary.
  always_ff @(posedge fast_clock) begin
    if (reset || flush) begin
      wr_ptr_r        <= {PW{1'b0}};
      rd_ptr_r        <= {PW{1'b0}};
      count_r         <= 4'd0;
      wb_enable_r     <= 1'b0;
      wb_control_r    <= 3'd0;
      wb_dest_r       <= 4'd0;
      wb_alu_result_r <= {REGISTER_LENGTH{1'b0}};
      wb_dfm_r        <= {REGISTER_LENGTH{1'b0}};
      wb_sp_r         <= {REGISTER_LENGTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_r + {3'b000, push_s} - {3'b000, pop_s};
      if (boundary_s) begin
        if (pop_s) begin
          wb_enable_r     <= 1'b1;
          wb_control_r    <= ctrl_mem_r[rd_ptr_r];
          wb_dest_r       <= dest_mem_r[rd_ptr_r];
          wb_alu_result_r <= data_mem_r[rd_ptr_r];
          wb_dfm_r        <= (ctrl_mem_r[rd_ptr_r] == CTRL_MEM) ? data_mem_r[rd_ptr_r]
                                                                : {REGISTER_LENGTH{1'b0}};
          wb_sp_r         <= sp_mem_r[rd_ptr_r];
        end else begin
          wb_enable_r     <= 1'b0;
          wb_control_r    <= 3'd0;
          wb_dest_r       <= 4'd0;
          wb_alu_result_r <= {REGISTER_LENGTH{1'b0}};
          wb_dfm_r        <= {REGISTER_LENGTH{1'b0}};
          wb_sp_r         <= {REGISTER_LENGTH{1'b0}};
        end
      end
    end
  end

  // OR of the write masks of every live FIFO slot plus the presented entry.
  always_comb begin
    pending_s = 16'h0000;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offset_s[i] = PW'(i) - rd_ptr_r;
      pending_s   = pending_s | ((4'(offset_s[i]) < count_r)
                                 ? pending_mask(ctrl_mem_r[i], dest_mem_r[i]) : 16'h0000);
    end
    pending_s = pending_s | (wb_enable_r ? pending_mask(wb_control_r, wb_dest_r) : 16'h0000);
  end

  assign pending             = pending_s;
  assign fifo_count          = count_r;
  assign wb_enable           = wb_enable_r;
  assign wb_control          = wb_control_r;
  assign wb_dest             = wb_dest_r;
  assign wb_alu_result       = wb_alu_result_r;
  assign wb_data_from_memory = wb_dfm_r;
  assign wb_new_SP           = wb_sp_r;

endmodule
